// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared constants and types for the AHB-lite transmit-only UART:
//   - register offsets (HADDR[3:2])
//   - STATUS bit positions
//   - serialiser FSM state type
//   - frame length in bit periods (start + 8 data + stop)
package uart_tx_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ahblite_uart_tx_if.sv
// ahblite_uart_tx_if
// AHB-lite bus bundle between the interconnect (master modport) and the
// UART responder (slave modport).
//   HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY : to slave
//   HREADYOUT, HRESP, HRDATA                                  : from slave
interface ahblite_uart_tx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO with first-word-fall-through output.
//   clk, RSTn   : clock, asynchronous active-low reset (flushes pointers)
//   push, din   : write request and byte (ignored while full)
//   pop, dout   : read request (ignored while empty) and current head byte
//   full, empty : occupancy flags; count: number of stored bytes
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // Full/empty are taken from the registered count, so a push into a full
  // FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is read combinationally so the serialiser can take the byte in the
  // same cycle it pops it.
  assign dout = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ahblite_uart_tx.sv
// ahblite_uart_tx
// Zero-wait-state AHB-lite responder with a transmit-only 8N1 UART.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   ahb           : AHB-lite slave bus (HREADYOUT=1, HRESP=OKAY always)
//   TXD           : serial output, idle high
//   TX_IRQ        : TX-done interrupt; implemented only when the macro
//                   UART_TX_IRQ_EN is defined, otherwise tied low
// Registers (HADDR[3:2]): 0 DATA (W), 1 STATUS (RO, bit3 W1C),
// 2 BAUDDIV (RW), 3 CTRL (RW bit0 irq_en, macro build only).
module ahblite_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahblite_uart_tx_if.slave ahb,
  output logic             TXD,
  output logic             TX_IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus pipeline
  logic       addr_valid;
  logic [1:0] addr_reg;
  logic       wr_pending_reg, rd_pending_reg;
  logic [15:0] bauddiv_reg;
  logic       ovf_reg;
  logic       irq_en;

  // FIFO
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  // Serialiser
  tx_state_e  state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_reg, shift_next;
  logic       txd_reg, txd_next;
  logic       bit_done;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HSIZE,
                             ahb.HPROT, ahb.HWDATA[31:16]};

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign addr_valid = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg       <= '0;
      wr_pending_reg <= 1'b0;
      rd_pending_reg <= 1'b0;
    end else begin
      wr_pending_reg <= addr_valid & ahb.HWRITE;
      rd_pending_reg <= addr_valid & ~ahb.HWRITE;
      if (addr_valid) addr_reg <= ahb.HADDR[3:2];
    end
  end

  assign fifo_push = wr_pending_reg && (addr_reg == REG_DATA);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bauddiv_reg <= BAUDDIV_RST;
      ovf_reg     <= 1'b0;
    end else begin
      if (wr_pending_reg && addr_reg == REG_BAUDDIV) bauddiv_reg <= ahb.HWDATA[15:0];
      // A new overflow wins over a simultaneous clear.
      if (fifo_push && fifo_full)
        ovf_reg <= 1'b1;
      else if (wr_pending_reg && addr_reg == REG_STATUS && ahb.HWDATA[ST_OVF])
        ovf_reg <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_reg, irq_reg;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_pending_reg && addr_reg == REG_CTRL) irq_en_reg <= ahb.HWDATA[0];
      irq_reg <= irq_en_reg & fifo_empty & (state_reg == IDLE);
    end
  end
  assign irq_en = irq_en_reg;
  assign TX_IRQ = irq_reg;
`else
  assign irq_en = 1'b0;
  assign TX_IRQ = 1'b0;
`endif

  always_comb begin
    ahb.HRDATA = '0;
    if (rd_pending_reg) begin
      case (addr_reg)
        REG_STATUS: begin
          ahb.HRDATA[ST_BUSY]                = (state_reg != IDLE);
          ahb.HRDATA[ST_FULL]                = fifo_full;
          ahb.HRDATA[ST_EMPTY]               = fifo_empty;
          ahb.HRDATA[ST_OVF]                 = ovf_reg;
          ahb.HRDATA[ST_COUNT_LSB+7:ST_COUNT_LSB] = 8'(fifo_count);
        end
        REG_BAUDDIV: ahb.HRDATA[15:0] = bauddiv_reg;
        REG_CTRL:    ahb.HRDATA[0]    = irq_en;
        default:     ahb.HRDATA       = '0;
      endcase
    end
  end

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (HCLK),
    .RSTn  (HRESETn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ahb.HWDATA[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // BAUDDIV is compared live; '>=' ends the bit at once if it is lowered
  // below the current count mid-bit.
  assign bit_done = (cnt_reg >= bauddiv_reg);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    fifo_pop     = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next   = '0;
          state_next = DATA;
        end else cnt_next = cnt_reg + 16'd1;
      end
      DATA: begin
        if (bit_done) begin
          cnt_next     = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end else cnt_next = cnt_reg + 16'd1;
      end
      STOP: begin
        if (bit_done) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else cnt_next = cnt_reg + 16'd1;
      end
      default: state_next = IDLE;
    endcase

    // TXD is registered from the next state so the pin never glitches.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  assign TXD = txd_reg;

endmodule

// File: tb/tb_ahblite_uart_tx.sv
// tb_ahblite_uart_tx
// Directed bench for ahblite_uart_tx (FIFO_DEPTH=8). TXD and TX_IRQ are
// logged every cycle so frame timing can be checked against the cycle of
// each write data phase. Build with UART_TX_IRQ_EN to cover the interrupt.
module tb_ahblite_uart_tx;
  import uart_tx_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic TXD, TX_IRQ;

  ahblite_uart_tx_if bus();

  ahblite_uart_tx #(.FIFO_DEPTH(8), .BAUDDIV_RST(16'd433)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus),
    .TXD     (TXD),
    .TX_IRQ  (TX_IRQ)
  );

  always #5 HCLK = ~HCLK;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_wr_cyc;
  logic hist_txd [0:4095];
  logic hist_irq [0:4095];
  logic irq_seen = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (cyc < 4096) begin
      hist_txd[cyc] = TXD;
      hist_irq[cyc] = TX_IRQ;
    end
    if (TX_IRQ === 1'b1) irq_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ahb_write(input logic [1:0] reg_idx, input logic [31:0] data);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
    bus.HADDR = {28'h0, reg_idx, 2'b00};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HWDATA = data;
    last_wr_cyc = cyc;
    $display("[%0d] wr reg%0d = 0x%08h", cyc, reg_idx, data);
  endtask

  task automatic ahb_read(input logic [1:0] reg_idx, output logic [31:0] data);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
    bus.HADDR = {28'h0, reg_idx, 2'b00};
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    #2;
    data = bus.HRDATA;
    $display("[%0d] rd reg%0d = 0x%08h", cyc, reg_idx, data);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge HCLK); #1;
    end
  endtask

  task automatic reset_pulse();
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  logic [31:0] rd;
  int          n, s;
  logic [7:0]  frame_bytes [3];
  logic        exp_bit;

  initial begin
    HRESETn    = 1'b0;
    bus.HSEL   = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
    bus.HPROT  = 4'h3; bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_txd", {31'h0, TXD}, 32'h1);
    check_val("rst_hrdata", bus.HRDATA, 32'h0);
    check_val("rst_irq", {31'h0, TX_IRQ}, 32'h0);
    check_val("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check_val("hresp", {31'h0, bus.HRESP}, 32'h0);
    HRESETn = 1'b1;

    // 1: reset values
    ahb_read(REG_STATUS, rd);  check_val("t1_status", rd, 32'h0000_0004);
    ahb_read(REG_BAUDDIV, rd); check_val("t1_bauddiv", rd, 32'd433);
    ahb_read(REG_DATA, rd);    check_val("t1_data_rd", rd, 32'h0);
    #1 check_val("t1_hrdata_idle", bus.HRDATA, 32'h0);

    // 2: 0xA5 at 4 cycles per bit
    ahb_write(REG_BAUDDIV, 32'd3);
    ahb_write(REG_DATA, 32'hA5);
    n = last_wr_cyc;
    wait_cyc(n + 45);
    check_val("t2_pre_fall", {31'h0, hist_txd[n+1]}, 32'h1);
    begin
      logic [9:0] seq;
      seq = 10'b1101001010; // bit i = expected level of bit period i
      for (int b = 0; b < 10; b++)
        check_val($sformatf("t2_bit%0d", b),
                  {28'h0, hist_txd[n+2+4*b], hist_txd[n+3+4*b], hist_txd[n+4+4*b], hist_txd[n+5+4*b]},
                  seq[b] ? 32'hF : 32'h0);
    end
    check_val("t2_after", {31'h0, hist_txd[n+42]}, 32'h1);
    ahb_read(REG_STATUS, rd); check_val("t2_status", rd, 32'h0000_0004);

    // 3: three back-to-back frames at 1 cycle per bit
    ahb_write(REG_BAUDDIV, 32'd0);
    frame_bytes[0] = 8'h00; frame_bytes[1] = 8'hFF; frame_bytes[2] = 8'h55;
    ahb_write(REG_DATA, 32'h00); n = last_wr_cyc;
    ahb_write(REG_DATA, 32'hFF);
    ahb_write(REG_DATA, 32'h55);
    ahb_read(REG_STATUS, rd); check_val("t3_status_cnt2", rd, 32'h0000_0201);
    wait_cyc(n + 40);
    s = n + 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) begin
        if (i == 0) exp_bit = 1'b0;
        else if (i == 9) exp_bit = 1'b1;
        else exp_bit = frame_bytes[f][i-1];
        check_val($sformatf("t3_f%0d_b%0d", f, i), {31'h0, hist_txd[s+11*f+i]}, {31'h0, exp_bit});
      end
      check_val($sformatf("t3_f%0d_idle", f), {31'h0, hist_txd[s+11*f+10]}, 32'h1);
    end
    ahb_read(REG_STATUS, rd); check_val("t3_status_end", rd, 32'h0000_0004);

    // 4: fill FIFO, overflow, W1C clear
    ahb_write(REG_BAUDDIV, 32'hFFFF);
    for (int k = 0; k < 9; k++) ahb_write(REG_DATA, 32'(k + 1));
    ahb_read(REG_STATUS, rd);  check_val("t4_full", rd, 32'h0000_0803);
    ahb_read(REG_BAUDDIV, rd); check_val("t4_bauddiv", rd, 32'h0000_FFFF);
    ahb_write(REG_DATA, 32'hEE);
    ahb_read(REG_STATUS, rd);  check_val("t4_ovf", rd, 32'h0000_080B);
    ahb_write(REG_STATUS, 32'h8);
    ahb_read(REG_STATUS, rd);  check_val("t4_ovf_clr", rd, 32'h0000_0803);

    // 5: asynchronous reset during data bit 3
    reset_pulse();
    ahb_write(REG_BAUDDIV, 32'd3);
    ahb_write(REG_DATA, 32'h00); n = last_wr_cyc;
    ahb_write(REG_DATA, 32'h00);
    s = n + 2;
    wait_cyc(s + 17);
    #2 check_val("t5_txd_pre", {31'h0, TXD}, 32'h0);
    HRESETn = 1'b0;
    #1 check_val("t5_txd_async", {31'h0, TXD}, 32'h1);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    ahb_read(REG_STATUS, rd);  check_val("t5_status", rd, 32'h0000_0004);
    ahb_read(REG_BAUDDIV, rd); check_val("t5_bauddiv", rd, 32'd433);

    // 6: interrupt
`ifdef UART_TX_IRQ_EN
    ahb_write(REG_CTRL, 32'h1);
    ahb_read(REG_CTRL, rd); check_val("t6_ctrl", rd, 32'h1);
    ahb_write(REG_BAUDDIV, 32'd1);
    ahb_write(REG_DATA, 32'h3C); n = last_wr_cyc;
    s = n + 2;
    wait_cyc(s + 24);
    check_val("t6_txd_fall", {30'h0, hist_txd[s-1], hist_txd[s]}, 32'h2);
    check_val("t6_irq_early", {31'h0, hist_irq[s+20]}, 32'h0);
    check_val("t6_irq_rise", {31'h0, hist_irq[s+21]}, 32'h1);
`else
    ahb_write(REG_CTRL, 32'h1);
    ahb_read(REG_CTRL, rd); check_val("t6_ctrl", rd, 32'h0);
    ahb_write(REG_BAUDDIV, 32'd1);
    ahb_write(REG_DATA, 32'h3C); n = last_wr_cyc;
    wait_cyc(n + 26);
    check_val("t6_irq_never", {31'h0, irq_seen}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
